ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Shares one RAM port between two instruction fetch ports and one data port.
// Data wins arbitration until instruction requests have waited STARVE_LIM grants.
//
// state | meaning
// IDLE  | no grant open; arbitrate requests seen this cycle
// DGNT  | data port owns the RAM
// IGNT0 | core 0 instruction fetch owns the RAM
// IGNT1 | core 1 instruction fetch owns the RAM
module ram_arbiter #(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr0,
    input  logic [31:0] iaddr1,
    output logic [1:0]  iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [TW-1:0] GCNT_MAX   = TW'(TIMEOUT);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGNT, IGNT0, IGNT1} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          last_i_q, last_i_d;
    logic [TW-1:0] gcnt_q, gcnt_d;
    logic          err_q, err_d;

    logic d_req, i_any, starve_hit, i_pick, gcore, done, abort;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            last_i_q <= 1'b1;
            gcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            last_i_q <= last_i_d;
            gcnt_q   <= gcnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        d_req      = dREN | dWEN;
        i_any      = |iREN;
        starve_hit = (starve_q == STARVE_MAX);
        // Single requester wins outright; two requesters alternate away from last_i.
        i_pick     = (iREN == 2'b11) ? ~last_i_q : iREN[1];
        gcore      = (state_q == IGNT1);
        done       = (ramstate == RS_ACCESS);
        abort      = (ramstate == RS_ERROR) || (gcnt_q == GCNT_MAX);

        state_d  = state_q;
        starve_d = starve_q;
        last_i_d = last_i_q;
        gcnt_d   = gcnt_q;
        err_d    = err_q;

        iwait    = 2'b11;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                if (d_req && !(starve_hit && i_any)) begin
                    state_d = DGNT;
                    gcnt_d  = '0;
                    if (i_any && !starve_hit) starve_d = starve_q + 1'b1;
                end else if (i_any) begin
                    state_d  = i_pick ? IGNT1 : IGNT0;
                    gcnt_d   = '0;
                    starve_d = '0;
                end
            end
            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (done) begin
                    dwait   = 1'b0;
                    dload   = dWEN ? '0 : ramload;
                    state_d = IDLE;
                end else if (abort) begin
                    dwait   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            IGNT0, IGNT1: begin
                ramREN  = 1'b1;
                ramaddr = gcore ? iaddr1 : iaddr0;
                if (!iREN[gcore]) begin
                    state_d = IDLE;
                end else if (done) begin
                    iwait[gcore] = 1'b0;
                    iload        = ramload;
                    last_i_d     = gcore;
                    state_d      = IDLE;
                end else if (abort) begin
                    iwait[gcore] = 1'b0;
                    err_d        = 1'b1;
                    state_d      = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err = err_q;

endmodule
